// File: rtl/revive_muldiv.sv
// revive_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// An operation is issued through a valid/ready port. It runs 32 iterations
// (shift-add multiply or restoring divide on operand magnitudes), then one
// sign-fixup cycle. The result is presented with a one-cycle strobe.
//
// Handshake: an operation is accepted on a rising edge where
//   op_vld && op_rdy && !op_kill.
// op_rdy is high only in IDLE and outside reset. Operand inputs are sampled
// on that edge only.
//
// Ports:
//   clk        in   core clock
//   rst        in   synchronous reset, active-high
//   op         in   funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op_a       in   rs1 operand (multiplicand / dividend)
//   op_b       in   rs2 operand (multiplier / divisor)
//   op_vld     in   issue request
//   op_rdy     out  unit idle, can accept
//   op_kill    in   abandon in-flight operation / block acceptance
//   result     out  result of the last completed operation
//   result_vld out  one-cycle strobe, result is new
//   dbg_state  out  FSM state (0 IDLE, 1 RUN, 2 FIXUP, 3 DONE)
module revive_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            op_vld,
  output logic            op_rdy,
  input  logic            op_kill,
  output logic [XLEN-1:0] result,
  output logic            result_vld,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIXUP = 2'd2, S_DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [31:0] opnd_q, opnd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  // Issue-side decode
  logic        accept;
  logic        is_div_in, sgn_a_in, sgn_b_in;
  logic [31:0] mag_a_in, mag_b_in;

  assign op_rdy    = (state_q == S_IDLE) && !rst;
  assign accept    = op_vld && op_rdy && !op_kill;
  assign is_div_in = op[2];
  assign sgn_a_in  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign sgn_b_in  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign mag_a_in  = (sgn_a_in && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b_in  = (sgn_b_in && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // One iteration step
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  // Partial remainder stays below the divisor, so the difference fits 32 bits.
  assign div_diff  = div_shift[31:0] - opnd_q;

  // Sign fixup
  logic        prod_neg;
  logic [63:0] prod;
  logic [31:0] quot_fix, rem_fix, fix_res;
  logic        div_zero;

  assign prod_neg = neg_a_q ^ neg_b_q;
  assign prod     = prod_neg ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = prod_neg ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  // Remainder follows the dividend sign. On divide-by-zero the remainder
  // register still holds |op_a|, so restoring the sign gives op_a exactly.
  assign rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
  assign div_zero = (opnd_q == 32'd0);

  always_comb begin
    fix_res = 32'd0;
    case (op_q)
      3'd0:       fix_res = prod[31:0];
      3'd1, 3'd2,
      3'd3:       fix_res = prod[63:32];
      3'd4, 3'd5: fix_res = div_zero ? 32'hFFFF_FFFF : quot_fix;
      default:    fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          op_d    = op;
          neg_a_d = sgn_a_in && op_a[31];
          neg_b_d = sgn_b_in && op_b[31];
          opnd_d  = is_div_in ? mag_b_in : mag_a_in;
          acc_d   = is_div_in ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
        end
      end
      S_RUN: begin
        if (op_kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (op_q[2]) begin
            acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                           : {div_shift[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          if (cnt_q == 6'd31) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (op_kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result     = result_q;
  assign result_vld = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_revive_muldiv.sv
module tb_revive_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        op_vld = 1'b0;
  logic        op_kill = 1'b0;
  logic        op_rdy;
  logic [31:0] result;
  logic        result_vld;
  logic [1:0]  dbg_state;

  revive_muldiv #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_vld     (op_vld),
    .op_rdy     (op_rdy),
    .op_kill    (op_kill),
    .result     (result),
    .result_vld (result_vld),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int unsigned acc_cyc_q[$];
  logic [31:0] pend_exp = 32'd0;
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned n_acc = 0, n_vld = 0, n_start = 0;
  logic [1:0]  prev_state = 2'd0;
  logic [31:0] mon_e;
  int unsigned mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (op_vld && op_rdy && !op_kill) begin
      exp_q.push_back(pend_exp);
      acc_cyc_q.push_back(cyc + 1);
      n_acc++;
    end
    if (prev_state == 2'd0 && dbg_state == 2'd1) n_start++;
    prev_state = dbg_state;
    if (result_vld === 1'b1) begin
      n_vld++;
      if (exp_q.size() == 0) begin
        check("unexpected_result_vld", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = acc_cyc_q.pop_front();
        check("result", result, mon_e);
        check("latency", cyc - mon_c, 32'd33);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    bit done;
    done = 0;
    op = o; op_a = a; op_b = b; pend_exp = e; op_vld = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (op_rdy) done = 1;
      @(posedge clk); #2;
    end
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk); #2;
  endtask

  task automatic run1(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    issue(o, a, b, e);
    op_vld = 1'b0;
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] saved;
  int unsigned v0, a0, s0;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_op_rdy", op_rdy, 32'd0);
    check("rst_result_vld", result_vld, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("op_rdy_after_rst", op_rdy, 32'd1);
    check("state_after_rst", dbg_state, 32'd0);
    @(posedge clk); #2;

    // Directed vectors
    run1(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run1(3'd3, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);
    run1(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run1(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run1(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run1(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run1(3'd5, 32'd100, 32'd7, 32'd14);
    run1(3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run1(3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run1(3'd6, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run1(3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678);
    run1(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run1(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run1(3'd7, 32'd100, 32'd7, 32'd2);

    // op_kill in IDLE blocks acceptance
    op = 3'd0; op_a = 32'd1; op_b = 32'd1; op_vld = 1'b1; op_kill = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("kill_blocks_accept", dbg_state, 32'd0);
    op_vld = 1'b0; op_kill = 1'b0;
    @(posedge clk); #2;

    // Kill 10 cycles into a DIV
    saved = result;
    v0 = n_vld;
    issue(3'd4, 32'd100, 32'd7, 32'd14);
    op_vld = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    op_kill = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    @(posedge clk); #2;
    op_kill = 1'b0;
    @(negedge clk);
    check("kill_op_rdy", op_rdy, 32'd1);
    check("kill_result_held", result, saved);
    @(posedge clk); #2;
    run1(3'd0, 32'd3, 32'd5, 32'd15);
    check("kill_pulse_count", n_vld - v0, 32'd1);

    // Reset mid-RUN
    v0 = n_vld;
    issue(3'd5, 32'd1000, 32'd3, 32'd333);
    op_vld = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    check("midrst_op_rdy_low", op_rdy, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_op_rdy", op_rdy, 32'd1);
    check("midrst_state", dbg_state, 32'd0);
    check("midrst_result", result, 32'd0);
    @(posedge clk); #2;
    run1(3'd0, 32'd3, 32'd5, 32'd15);
    check("midrst_pulse_count", n_vld - v0, 32'd1);

    // Back-to-back random ops with op_vld held high
    v0 = n_vld; a0 = n_acc; s0 = n_start;
    for (int i = 0; i < 8; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 15)) : $urandom);
      issue(r_op, r_a, r_b, model(r_op, r_a, r_b));
    end
    op_vld = 1'b0;
    wait_done();
    check("rand_accepts", n_acc - a0, 32'd8);
    check("rand_starts", n_start - s0, 32'd8);
    check("rand_pulses", n_vld - v0, 32'd8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    check("watchdog", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/revive_muldiv.md
# revive_muldiv

Iterative RV32M multiply/divide unit for the RISCBoy core. It sits beside the single-cycle ALU in the execute stage and takes the same operand pair. It handles the M-extension operations the ALU cannot complete in one cycle, one bit per cycle, and returns a 32-bit result through a valid/ready issue port and a one-cycle result strobe. The control logic stalls the pipeline while `op_rdy` is low and can abandon an operation on a flush.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `op`  in  3  operation, RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a`  in  XLEN  rs1 operand (multiplicand/dividend).
- `op_b`  in  XLEN  rs2 operand (multiplier/divisor).
- `op_vld`  in  1  issue request; `op`/`op_a`/`op_b` are valid.
- `op_rdy`  out  1  unit idle and able to accept an operation.
- `op_kill`  in  1  abandon any in-flight operation (pipeline flush).
- `result`  out  XLEN  result of the last completed operation.
- `result_vld`  out  1  one-cycle strobe: `result` is new this cycle.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- `op_rdy` = (state == IDLE) && !rst.
- Accept occurs on an edge where `op_vld && op_rdy && !op_kill`. On accept, the unit latches `op` and the operand signs, and stores operand magnitudes:
  - signed-ness per operand: MULH, DIV, REM: a and b signed; MULHSU: a signed, b unsigned; MUL, MULHU, DIVU, REMU: both unsigned.
  - MUL takes the low word, so signedness is irrelevant.
- RUN: 32 iterations and a 6-bit counter.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division; 32-bit partial remainder plus quotient register.
- FIXUP, one cycle:
  - Multiply: negate the 64-bit product if the operand signs differ (considering signed operands only). Select the low word for MUL and the high word for the others.
  - DIV: negate the quotient if the signs differ.
  - REM: the remainder takes the sign of the dividend.
- Divide by zero: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = op_a unchanged for REM and REMU. The sign fixup is bypassed.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of sign-magnitude arithmetic and must not be special-cased incorrectly.
- DONE: `result` is updated and `result_vld` = 1 for exactly one cycle, then the unit returns to IDLE.
- `result` holds its value between completions.
- `op_kill`:
  - In RUN, FIXUP or DONE: the unit enters IDLE on the next edge and `result_vld` does not pulse. If the kill arrives in DONE, the strobe in that same cycle has already been seen.
  - In IDLE: `op_kill` blocks acceptance for that cycle.
- Operand inputs are ignored outside the accept edge.

## Timing
- Reset values: state IDLE, `result` = 0, `result_vld` = 0, `op_rdy` = 0 while `rst` is high and 1 on the first cycle after `rst` falls.
- Reset asserted mid-operation: the unit is in IDLE after the reset edge and there is no `result_vld`.
- Accept at edge E0. RUN occupies the cycles after E0 through E32; FIXUP follows E32; DONE follows E33.
- `result_vld` is high between E33 and E34, i.e. 33 cycles of latency from the accepting edge.
- `op_rdy` rises after E34. Peak throughput is one operation per 35 cycles.
- The latency is fixed and data-independent; there is no early termination.
- No combinational path from inputs to `result`/`result_vld`. `op_rdy` depends only on state and `rst`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): `result_vld` exactly 33 cycles after accept, `result` = 0xFFFFFFEB. MULHU of the same operands → 0x00000006.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Divide by zero with op_a = 0x12345678: DIV → 0xFFFFFFFF, DIVU → 0xFFFFFFFF, REM → 0x12345678, REMU → 0x12345678. Overflow 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- Pulse `op_kill` 10 cycles into a DIV: no `result_vld`, `op_rdy` high on the next cycle, `result` unchanged. A new MUL 3 × 5 issued immediately afterwards returns 15. Separately, assert `rst` mid-RUN: same recovery behaviour.
- Hold `op_vld` high continuously with 8 random operations and check each against a reference model: each is accepted only when `op_rdy` is high, and exactly one `result_vld` pulse occurs per accept.
